// File: rtl/morse_pkg.sv
// Shared types and character constants for the Morse stream decoder.
package morse_pkg;

  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam logic [7:0] CH_A = 8'h41, CH_B = 8'h42, CH_C = 8'h43, CH_D = 8'h44;
  localparam logic [7:0] CH_E = 8'h45, CH_F = 8'h46, CH_G = 8'h47, CH_H = 8'h48;
  localparam logic [7:0] CH_I = 8'h49, CH_J = 8'h4A, CH_K = 8'h4B, CH_L = 8'h4C;
  localparam logic [7:0] CH_M = 8'h4D, CH_N = 8'h4E, CH_O = 8'h4F, CH_P = 8'h50;
  localparam logic [7:0] CH_Q = 8'h51, CH_R = 8'h52, CH_S = 8'h53, CH_T = 8'h54;
  localparam logic [7:0] CH_U = 8'h55, CH_V = 8'h56, CH_W = 8'h57, CH_X = 8'h58;
  localparam logic [7:0] CH_Y = 8'h59, CH_Z = 8'h5A;

  localparam logic [7:0] CH_0 = 8'h30, CH_1 = 8'h31, CH_2 = 8'h32, CH_3 = 8'h33;
  localparam logic [7:0] CH_4 = 8'h34, CH_5 = 8'h35, CH_6 = 8'h36, CH_7 = 8'h37;
  localparam logic [7:0] CH_8 = 8'h38, CH_9 = 8'h39;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_OVERFLOW = 2'd1,
    ERR_UNKNOWN  = 2'd2,
    ERR_DROP     = 2'd3
  } err_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_SPACE   = 2'd3
  } state_t;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse code-word to ASCII lookup.
// Code word: first symbol at the MSB of the used length, dot=0, dash=1.
module morse_lut
  import morse_pkg::*;
#(
  parameter int MAX_SYMS  = 6,
  parameter int EN_DIGITS = 1
) (
  input  logic [MAX_SYMS-1:0]           code_i,
  input  logic [$clog2(MAX_SYMS+1)-1:0] len_i,
  output logic                          hit_o,
  output logic [7:0]                    ascii_o
);

  // Only the low five symbols can ever form a mapped character.
  logic [4:0] c5;

  if (MAX_SYMS >= 5) begin : g_wide
    assign c5 = code_i[4:0];
    if (MAX_SYMS > 5) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^code_i[MAX_SYMS-1:5];
    end
  end else begin : g_narrow
    assign c5 = 5'(code_i);
  end

  // Decode by length, then by code pattern.
  always_comb begin
    hit_o   = 1'b1;
    ascii_o = '0;
    case (int'(len_i))
      1: begin
        case (c5[0])
          1'b0:    ascii_o = CH_E;
          default: ascii_o = CH_T;
        endcase
      end
      2: begin
        case (c5[1:0])
          2'b00:   ascii_o = CH_I;
          2'b01:   ascii_o = CH_A;
          2'b10:   ascii_o = CH_N;
          default: ascii_o = CH_M;
        endcase
      end
      3: begin
        case (c5[2:0])
          3'b000:  ascii_o = CH_S;
          3'b001:  ascii_o = CH_U;
          3'b010:  ascii_o = CH_R;
          3'b011:  ascii_o = CH_W;
          3'b100:  ascii_o = CH_D;
          3'b101:  ascii_o = CH_K;
          3'b110:  ascii_o = CH_G;
          default: ascii_o = CH_O;
        endcase
      end
      4: begin
        case (c5[3:0])
          4'b0000: ascii_o = CH_H;
          4'b0001: ascii_o = CH_V;
          4'b0010: ascii_o = CH_F;
          4'b0100: ascii_o = CH_L;
          4'b0110: ascii_o = CH_P;
          4'b0111: ascii_o = CH_J;
          4'b1000: ascii_o = CH_B;
          4'b1001: ascii_o = CH_X;
          4'b1010: ascii_o = CH_C;
          4'b1011: ascii_o = CH_Y;
          4'b1100: ascii_o = CH_Z;
          4'b1101: ascii_o = CH_Q;
          default: hit_o   = 1'b0;
        endcase
      end
      5: begin
        if (EN_DIGITS != 0) begin
          case (c5)
            5'b11111: ascii_o = CH_0;
            5'b01111: ascii_o = CH_1;
            5'b00111: ascii_o = CH_2;
            5'b00011: ascii_o = CH_3;
            5'b00001: ascii_o = CH_4;
            5'b00000: ascii_o = CH_5;
            5'b10000: ascii_o = CH_6;
            5'b11000: ascii_o = CH_7;
            5'b11100: ascii_o = CH_8;
            5'b11110: ascii_o = CH_9;
            default:  hit_o   = 1'b0;
          endcase
        end else begin
          hit_o = 1'b0;
        end
      end
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_stream_decoder.sv
// Morse stream decoder: collects dot/dash strobes into a code word, decodes on
// letter/word gaps, and buffers ASCII characters in a valid/ready output FIFO.
module morse_stream_decoder
  import morse_pkg::*;
#(
  parameter int MAX_SYMS   = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int EN_DIGITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dot,
  input  logic       dash,
  input  logic       lg,
  input  logic       wg,
  input  logic       dready,
  output logic [7:0] dout,
  output logic       dvalid,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int LW = $clog2(MAX_SYMS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  state_t              state_q, state_d;
  logic [MAX_SYMS-1:0] code_q, code_d;
  logic [LW-1:0]       len_q, len_d;
  logic                last_space_q, last_space_d;
  logic                error_q, error_d;
  err_t                err_code_q, err_code_d;
  logic [PW-1:0]       wp_q, rp_q;
  logic [6:0]          mem_q [FIFO_DEPTH];

  logic       lut_hit;
  logic [7:0] lut_ascii;
  logic       push_req;
  logic [7:0] push_char;
  logic       ovf, unk;
  logic       gap, one_sym;
  logic       empty, full, pop, push_ok, drop;
  logic       unused_b7;

  morse_lut #(
    .MAX_SYMS  (MAX_SYMS),
    .EN_DIGITS (EN_DIGITS)
  ) u_lut (
    .code_i  (code_q),
    .len_i   (len_q),
    .hit_o   (lut_hit),
    .ascii_o (lut_ascii)
  );

  assign gap       = lg | wg;
  assign one_sym   = dot ^ dash;
  assign unused_b7 = push_char[7];

  // FIFO status; a same-cycle pop frees the slot a full push needs.
  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop     = !empty && dready;
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && !push_ok;

  assign dvalid   = !empty;
  assign dout     = empty ? '0 : {1'b0, mem_q[rp_q[AW-1:0]]};
  assign error    = error_q;
  assign err_code = err_code_q;

  // Next-state, code-word update and character push requests.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    len_d        = len_q;
    last_space_d = last_space_q;
    push_req     = 1'b0;
    push_char    = CH_SPACE;
    ovf          = 1'b0;
    unk          = 1'b0;

    // A gap beats any coincident symbol; dot+dash together is never appended.
    if (gap && (dot || dash)) begin
      unk = 1'b1;
    end else if (!gap && dot && dash) begin
      unk = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (gap) begin
          if (wg && !last_space_q) begin
            push_req     = 1'b1;
            push_char    = CH_SPACE;
            last_space_d = 1'b1;
          end
        end else if (one_sym) begin
          code_d  = MAX_SYMS'(dash);
          len_d   = LW'(1);
          state_d = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (gap) begin
          if (lut_hit) begin
            push_req     = 1'b1;
            push_char    = lut_ascii;
            last_space_d = 1'b0;
          end else begin
            unk = 1'b1;
          end
          code_d  = '0;
          len_d   = '0;
          state_d = wg ? ST_SPACE : ST_IDLE;
        end else if (one_sym) begin
          if (len_q == LW'(MAX_SYMS)) begin
            ovf     = 1'b1;
            code_d  = '0;
            len_d   = '0;
            state_d = ST_FLUSH;
          end else begin
            code_d = {code_q[MAX_SYMS-2:0], dash};
            len_d  = len_q + LW'(1);
          end
        end
      end

      ST_FLUSH: begin
        // The code word was already cleared on entry; symbols here are discarded.
        if (gap) begin
          state_d = ST_IDLE;
          if (wg) begin
            push_req     = 1'b1;
            push_char    = CH_SPACE;
            last_space_d = 1'b1;
          end
        end
      end

      ST_SPACE: begin
        // Space is pushed unconditionally; a wg here is then a duplicate and ignored.
        push_req     = 1'b1;
        push_char    = CH_SPACE;
        last_space_d = 1'b1;
        state_d      = ST_IDLE;
        if (!gap && one_sym) begin
          code_d  = MAX_SYMS'(dash);
          len_d   = LW'(1);
          state_d = ST_COLLECT;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Error pulse and sticky cause; a drop outranks unknown, which outranks overflow.
  always_comb begin
    error_d    = ovf | unk | drop;
    err_code_d = err_code_q;
    if (drop) begin
      err_code_d = ERR_DROP;
    end else if (unk) begin
      err_code_d = ERR_UNKNOWN;
    end else if (ovf) begin
      err_code_d = ERR_OVERFLOW;
    end
  end

  // Control state, code word, flags and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      code_q       <= '0;
      len_q        <= '0;
      last_space_q <= 1'b1;
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
      wp_q         <= '0;
      rp_q         <= '0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      len_q        <= len_d;
      last_space_q <= last_space_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      if (push_ok) begin
        wp_q <= wp_q + PW'(1);
      end
      if (pop) begin
        rp_q <= rp_q + PW'(1);
      end
    end
  end

  // FIFO storage; bit 7 of ASCII is always zero so only 7 bits are kept.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wp_q[AW-1:0]] <= push_char[6:0];
    end
  end

endmodule
